// File: rtl/sr_pkg.sv
// Shared types and constants for the iterative right shifter.
package sr_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } sr_state_t;

    localparam logic SR_LOGICAL = 1'b0;
    localparam logic SR_ARITH   = 1'b1;

endpackage

// File: rtl/sr_step.sv
// Single-bit right shift of an N-bit word, fill bit supplied by the caller; purely combinational.
module sr_step #(
    parameter int N = 32
) (
    input  logic [N-1:0] i_data,
    input  logic         i_fill,
    output logic [N-1:0] o_data
);

    assign o_data = {i_fill, i_data[N-1:1]};

endmodule

// File: rtl/sr_iter.sv
// Iterative right shifter (logical/arithmetic), one bit per cycle; result after k edges past accept.
// Result is held in DONE until out_ready; requests accepted only in IDLE.
module sr_iter
    import sr_pkg::*;
#(
    parameter int N = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N-1:0]         in_data,
    input  logic [$clog2(N)-1:0] in_shamt,
    input  logic                 in_arith,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [N-1:0]         out_data,
    output logic                 busy
);

    localparam int             CW      = $clog2(N);
    localparam logic [CW-1:0]  CNT_ONE = CW'(1);
    localparam logic [CW-1:0]  CNT_ZERO = '0;

    sr_state_t      r_state;
    logic [CW-1:0]  r_cnt;
    logic [N-1:0]   r_data;
    logic           r_arith;
    logic           w_fill;
    logic [N-1:0]   w_shifted;

    assign w_fill = (r_arith == SR_ARITH) ? r_data[N-1] : 1'b0;

    sr_step #(.N(N)) u_step (
        .i_data (r_data),
        .i_fill (w_fill),
        .o_data (w_shifted)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_data  <= '0;
            r_arith <= SR_LOGICAL;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_data  <= in_data;
                        r_arith <= in_arith;
                        r_cnt   <= in_shamt;
                        r_state <= (in_shamt == CNT_ZERO) ? DONE : SHIFT;
                    end
                end
                SHIFT: begin
                    r_data <= w_shifted;
                    r_cnt  <= r_cnt - CNT_ONE;
                    // Counter still holds the pending shift count, so 1 means this is the last one.
                    if (r_cnt == CNT_ONE) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign busy      = (r_state != IDLE);
    assign out_data  = r_data;

endmodule

// File: tb/tb_sr_iter.sv
// Bench for sr_iter: directed vector table, hand-built corner sequences, and randomized operations.
module tb_sr_iter;

    localparam int N = 32;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  in_data;
    logic [4:0]    in_shamt;
    logic          in_arith;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  out_data;
    logic          busy;

    int n_tests = 0;
    int n_fail  = 0;

    sr_iter #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_shamt  (in_shamt),
        .in_arith  (in_arith),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        logic [4:0]  k;
        logic        a;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [31:0] d, input int k, input logic a);
        logic [31:0] r;
        if (a) r = $signed(d) >>> k;
        else   r = d >> k;
        return r;
    endfunction

    // Starts #1 after an edge with the DUT idle; returns result, edges from accept to out_valid.
    task automatic run_op(input logic [31:0] d, input logic [4:0] k, input logic a, input int hold,
                          output logic [31:0] res, output int lat);
        in_valid = 1'b1; in_data = d; in_shamt = k; in_arith = a; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            in_data = $urandom; in_shamt = 5'($urandom); in_arith = 1'($urandom);
            @(posedge clk); #1;
            lat++;
        end
        if (lat >= 100) chk("timeout_out_valid", 64'(out_valid), 64'd1);
        res = out_data;
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1; in_data = $urandom; in_shamt = 5'($urandom);
            @(posedge clk); #1;
            chk("hold_stable", {32'(in_ready), out_data}, {32'd0, res});
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] res;
        int          lat;
        logic [31:0] d;
        logic [4:0]  k;
        logic        a;
        int          seen;

        vecs[0] = '{32'h8000_00F0, 5'd4,  1'b0, 32'h0800_000F};
        vecs[1] = '{32'h8000_00F0, 5'd4,  1'b1, 32'hF800_000F};
        vecs[2] = '{32'hDEAD_BEEF, 5'd0,  1'b1, 32'hDEAD_BEEF};
        vecs[3] = '{32'h8000_0000, 5'd31, 1'b1, 32'hFFFF_FFFF};
        vecs[4] = '{32'h8000_0000, 5'd31, 1'b0, 32'h0000_0001};
        vecs[5] = '{32'h7FFF_FFFF, 5'd1,  1'b1, 32'h3FFF_FFFF};
        vecs[6] = '{32'hC000_0003, 5'd2,  1'b0, 32'h3000_0000};

        rst_n = 1'b1; in_valid = 1'b0; in_data = '0; in_shamt = '0; in_arith = 1'b0; out_ready = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("reset_outputs", {28'd0, in_ready, out_valid, busy, 1'b0, out_data}, {28'd0, 4'b1000, 32'd0});
        #10 rst_n = 1'b1;

        // Directed vectors; the first one also checks acceptance on the first edge after reset.
        foreach (vecs[i]) begin
            run_op(vecs[i].d, vecs[i].k, vecs[i].a, 0, res, lat);
            chk($sformatf("vec%0d_data", i), 64'(res), 64'(vecs[i].exp));
            chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].k));
        end

        // Backpressure: result held 10 cycles, then a new accept right after release.
        run_op(32'h1234_5678, 5'd3, 1'b0, 10, res, lat);
        chk("bp_data", 64'(res), 64'h0246_8ACF);
        chk("bp_ready_after", 64'(in_ready), 64'd1);

        // No accept while leaving DONE, even with in_valid and out_ready both high.
        in_valid = 1'b1; in_data = 32'hF000_0000; in_shamt = 5'd2; in_arith = 1'b1;
        @(posedge clk); #1;
        while (!out_valid && n_tests < 100000) begin
            in_data = $urandom;
            @(posedge clk); #1;
        end
        in_data = 32'h0000_00FF; in_shamt = 5'd1; in_arith = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        chk("done_no_accept", {62'd0, in_ready, out_valid}, {62'd0, 2'b10});
        out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("accept_after_done", {62'd0, in_ready, busy}, {62'd0, 2'b01});
        @(posedge clk); #1;
        chk("accept_after_done_data", {31'd0, out_valid, out_data}, {31'd0, 1'b1, 32'h0000_007F});
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;

        // Reset abort 3 cycles into a 20-bit shift.
        in_valid = 1'b1; in_data = 32'hA5A5_A5A5; in_shamt = 5'd20; in_arith = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        chk("abort_busy_before", 64'(busy), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_async_outputs", {28'd0, in_ready, out_valid, busy, 1'b0, out_data}, {28'd0, 4'b1000, 32'd0});
        @(posedge clk); #3 rst_n = 1'b1;
        seen = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        chk("abort_no_valid", 64'(seen), 64'd0);
        run_op(32'h8765_4321, 5'd8, 1'b1, 0, res, lat);
        chk("abort_next_data", 64'(res), 64'(model(32'h8765_4321, 8, 1'b1)));
        chk("abort_next_latency", 64'(lat), 64'd8);

        // Randomized operations against the arithmetic model.
        for (int t = 0; t < 40; t++) begin
            d = $urandom;
            k = 5'($urandom_range(0, 31));
            a = 1'($urandom);
            run_op(d, k, a, int'($urandom_range(0, 2)), res, lat);
            chk($sformatf("rand%0d_data", t), 64'(res), 64'(model(d, int'(k), a)));
            chk($sformatf("rand%0d_latency", t), 64'(lat), 64'(k));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/sr_iter.md
SR_ITER -- requirements
Module: sr_iter

Interface
REQ-001 Parameter N, default 32, data width in bits; legal values are powers of two, 2 to 64.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 in_valid  input  1  request present on in_data/in_shamt/in_arith.
REQ-005 in_ready  output  1  block can accept a request.
REQ-006 in_data  input  N  operand to shift right.
REQ-007 in_shamt  input  $clog2(N)  shift amount, 0 to N-1.
REQ-008 in_arith  input  1  1 = arithmetic (sign fill), 0 = logical (zero fill).
REQ-009 out_valid  output  1  result on out_data is valid.
REQ-010 out_ready  input  1  consumer takes the result.
REQ-011 out_data  output  N  shifted result.
REQ-012 busy  output  1  high in SHIFT or DONE.

Function
REQ-013 The block SHALL implement three states: IDLE, SHIFT, DONE.
REQ-014 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-015 Accept edge: the edge where in_valid and in_ready are both 1; it latches in_data, in_shamt and in_arith into internal registers.
REQ-016 On the accept edge, the state SHALL go to DONE if in_shamt == 0; otherwise it SHALL go to SHIFT with the counter loaded to in_shamt.
REQ-017 Each SHIFT edge: the data register SHALL shift right by exactly 1 bit and the counter SHALL decrement by 1.
  - Fill bit = MSB of the data register when arith = 1, else 0.
REQ-018 In SHIFT, when counter == 1 the next edge SHALL perform the final shift and move the state to DONE.
REQ-019 Latency: for amount k, out_valid SHALL rise after the k-th edge following the accept edge (k+1 cycles from the accept cycle); k = 0 gives 1 cycle.
REQ-020 In DONE, out_data SHALL hold stable until out_valid && out_ready; on that edge the state SHALL return to IDLE.
REQ-021 No request SHALL be accepted in DONE, even when out_ready is 1 in the same cycle; the next accept is possible one cycle later.
REQ-022 in_data, in_shamt and in_arith SHALL be ignored outside the accept edge; changing them mid-operation SHALL have no effect.
REQ-023 Result SHALL equal in_data >> k (logical) or $signed(in_data) >>> k (arithmetic), bit-exact.
REQ-024 out_data SHALL equal the data register; its value outside DONE is don't-care for the consumer but deterministic.

Reset
REQ-025 On rst_n low, the block SHALL reset immediately, without waiting for clk:
  - state = IDLE, counter = 0, data register = 0;
  - outputs: out_valid = 0, busy = 0, in_ready = 1, out_data = 0.
REQ-026 Reset asserted in SHIFT or DONE SHALL abort the operation; the pending result is discarded and never presented.
REQ-027 After rst_n deasserts, a request SHALL be acceptable on the first rising edge.

Structure
REQ-028 A shared package sr_pkg SHALL hold:
  - the state typedef sr_state_t (IDLE, SHIFT, DONE);
  - the fill-mode constants SR_LOGICAL = 0 and SR_ARITH = 1.
REQ-029 One sub-module, sr_step, SHALL be instantiated: combinational 1-bit right shift of an N-bit word with a fill-bit input.
REQ-030 Counter width SHALL be $clog2(N); no multi-bit shifter SHALL be inferred.

Verification
REQ-031 Logical shift: N=32, in_data=32'h8000_00F0, shamt=4, arith=0 -> out_data=32'h0800_000F; out_valid rises 5 cycles after the accept cycle.
REQ-032 Arithmetic shift: in_data=32'h8000_00F0, shamt=4, arith=1 -> out_data=32'hF800_000F.
REQ-033 Zero shift: shamt=0, in_data=32'hDEAD_BEEF -> out_data=32'hDEAD_BEEF, out_valid in the cycle after accept.
REQ-034 Maximum shift: shamt=31 on in_data=32'h8000_0000:
  - arith=1 -> 32'hFFFF_FFFF;
  - arith=0 -> 32'h0000_0001;
  - latency 32 cycles in both cases.
REQ-035 Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_data stable, in_ready=0 throughout; raising out_ready then allows a new accept one cycle later.
REQ-036 Reset abort: assert rst_n low 3 cycles into a shamt=20 shift -> all outputs reset asynchronously; no out_valid pulse follows; the next request completes correctly.
